control_fsm: RTL and testbench
==============================

# control_fsm

Multicycle main controller for the RV32I-subset core: sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write enables, and produces the 3-bit `alu_control` code consumed by the ALU. It also consumes the ALU `zero` and `negative` flags to resolve branches. It sits between the instruction register and the datapath, opposite the ALU on the control/flag interface.

## Interface
- No parameters.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `opcode` input 7: instruction[6:0] from the instruction register.
- `funct3` input 3: instruction[14:12].
- `funct7_5` input 1: instruction[30].
- `zero` input 1: ALU zero flag.
- `negative` input 1: ALU result[31] flag.
- `mem_ready` input 1: memory completed the current access this cycle.
- `pc_write` output 1: PC register load enable.
- `ir_write` output 1: instruction and old-PC register load enable.
- `reg_write` output 1: register-file write enable.
- `mem_write` output 1: memory write strobe.
- `adr_src` output 1: memory address select. 0 = PC, 1 = result bus.
- `alu_src_a` output 2: ALU source 1 select. 00 = PC, 01 = old PC, 10 = rs1 register.
- `alu_src_b` output 2: ALU source 2 select. 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `result_src` output 2: result bus select. 00 = ALUOut register, 01 = memory data register, 10 = ALU result.
- `alu_control` output 3: 000 add, 001 sub, 010 and, 011 or, 101 set-less-than.
- `instr_done` output 1: one-cycle pulse in the final state of each instruction.
- `illegal_instr` output 1: one-cycle pulse in DECODE when the opcode/funct combination is unsupported.
- `state` output 4: current state encoding, for debug.

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5.
  - EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10.
  - Encodings 11–15 are unreachable and decode to FETCH.
- Outputs are Moore decodes of `state`, except these Mealy terms:
  - `mem_ready` gating in FETCH, MEMREAD and MEMWRITE.
  - Branch `pc_write`.
  - DECODE `illegal_instr`.
- Unlisted outputs are 0. `alu_control` defaults to 000.
- FETCH:
  - Drives `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10.
  - `ir_write` and `pc_write` are asserted only while `mem_ready`=1.
  - Advances to DECODE when `mem_ready`=1; otherwise holds.
- DECODE:
  - Drives `alu_src_a`=01, `alu_src_b`=01, add (branch/jump target into ALUOut).
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1101111 → JAL.
    - 1100011 → BRANCH.
  - Any other opcode, an unsupported funct3 for R/I (supported: 000, 010, 110, 111), or a branch funct3 other than 000, 001, 100: pulse `illegal_instr`, return to FETCH, no writes.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `adr_src`=1, `result_src`=00. Goes to MEMWB when `mem_ready`=1.
- MEMWB: `result_src`=01, `reg_write`=1, `instr_done`=1. Goes to FETCH.
- MEMWRITE:
  - `adr_src`=1, `result_src`=00, `mem_write`=1 held while waiting.
  - When `mem_ready`=1: `instr_done`=1, go to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00. Goes to ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01. Goes to ALUWB.
- ALU function decode (EXECR/EXECI), by funct3:
  - 000: sub if R-type and `funct7_5`=1, else add. addi ignores `funct7_5`.
  - 010: 101.
  - 110: 011.
  - 111: 010.
- ALUWB: `result_src`=00, `reg_write`=1, `instr_done`=1. Goes to FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`=1. Goes to ALUWB, which writes PC+4 to rd.
- BRANCH:
  - `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00, `instr_done`=1. Goes to FETCH.
  - `pc_write` is asserted in this cycle when the condition holds:
    - beq: `zero`=1.
    - bne: `zero`=0.
    - blt: `negative`=1. Signed overflow is ignored.

## Timing
- While `reset`=1, state is FETCH and every output is forced to 0 (`state` reads 0). Reset release, mid-instruction assertion or otherwise, aborts the instruction with no writes.
- Cycle counts with `mem_ready` tied high:
  - lw: 5.
  - sw, R-type, I-type, jal: 4.
  - Branch: 3.
  - Illegal instruction: 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle, with outputs held stable.
- `pc_write` asserts at most once in FETCH per instruction, plus at most once in JAL or BRANCH.
- `instr_done` and `reg_write` never assert in the same instruction as `illegal_instr`.

## Test plan
- Reset asserted mid-MEMWRITE with `mem_ready`=0 → all outputs 0 immediately; after release, `state`=0 and `mem_write`=0.
- R-type sub (opcode 0110011, funct3 000, `funct7_5`=1), `mem_ready`=1 → states 0,1,6,7; `alu_control`=001 in EXECR; `reg_write`=1 only in ALUWB; `instr_done` pulse on cycle 4.
- lw with `mem_ready` low 2 cycles in MEMREAD → states 0,1,2,3,3,3,4; `adr_src`=1 throughout MEMREAD; `reg_write` only in MEMWB.
- bne with `zero`=0, then again with `zero`=1 → `pc_write`=1, then `pc_write`=0 in BRANCH; `alu_control`=001; both take 3 cycles.
- opcode 0110111 (lui, unsupported) → `illegal_instr` pulse in DECODE, back to FETCH, no `reg_write`/`mem_write`/`instr_done`.
- FETCH with `mem_ready`=0 for 3 cycles → `pc_write`=`ir_write`=0 for those cycles, single `pc_write` pulse on the ready cycle.

Source files
------------

// File: rtl/control_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_fsm_if
//  Description : Control/flag bundle between the multicycle main controller
//                and the datapath / instruction register.
//                master : controller side. It consumes instruction fields,
//                         ALU flags and mem_ready, and drives selects/enables.
//                slave  : datapath side, with the opposite directions.
//  Signals     : opcode[6:0], funct3[2:0], funct7_5, zero, negative,
//                mem_ready                                   (to controller)
//                pc_write, ir_write, reg_write, mem_write, adr_src,
//                alu_src_a[1:0], alu_src_b[1:0], result_src[1:0],
//                alu_control[2:0], instr_done, illegal_instr, state[3:0]
//                                                          (from controller)
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       negative;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_instr;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, funct7_5, zero, negative, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, alu_control,
               instr_done, illegal_instr, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, negative, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, alu_control,
               instr_done, illegal_instr, state
    );
endinterface
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : control_fsm
//  Description : Multicycle main controller for the RV32I-subset core.
//                Steps each instruction through fetch, decode, execute,
//                memory and writeback. It drives the datapath selects and
//                enables, and resolves branches from the ALU zero/negative
//                flags.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous, active-high. It holds the FSM in FETCH
//                        and forces every output to 0.
//                bus   - control_fsm_if.master. It carries the instruction
//                        fields, flags and mem_ready in, and the control word
//                        and debug state out.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_fsm (
    input  wire logic     clk,
    input  wire logic     reset,
    control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    state_t r_state;
    state_t w_next_state;

    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_adr_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_result_src;
    logic [2:0] w_alu_control;
    logic       w_instr_done;
    logic       w_illegal;

    logic       w_alu_f3_ok;
    logic       w_br_f3_ok;
    logic       w_br_taken;
    logic [2:0] w_alu_fn;

    // The instruction register is loaded only in FETCH. Opcode and funct
    // fields therefore stay stable for the rest of the instruction, and
    // later states can decode them again without a private copy.
    always_comb begin
        w_alu_f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
        w_br_f3_ok  = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b100);
    end

    // Branch condition. blt uses the sign of rs1-rs2 only, so signed
    // overflow is deliberately not compensated.
    always_comb begin
        case (bus.funct3)
            3'b000:  w_br_taken = bus.zero;
            3'b001:  w_br_taken = ~bus.zero;
            3'b100:  w_br_taken = bus.negative;
            default: w_br_taken = 1'b0;
        endcase
    end

    // funct7_5 selects sub only for R-type. addi shares funct3=000 but its
    // bit 30 belongs to the immediate.
    always_comb begin
        case (bus.funct3)
            3'b010:  w_alu_fn = c_ALU_SLT;
            3'b110:  w_alu_fn = c_ALU_OR;
            3'b111:  w_alu_fn = c_ALU_AND;
            default: w_alu_fn = ((r_state == S_EXECR) && bus.funct7_5) ? c_ALU_SUB
                                                                        : c_ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = S_FETCH;
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_write   = 1'b0;
        w_adr_src     = 1'b0;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_result_src  = 2'b00;
        w_alu_control = c_ALU_ADD;
        w_instr_done  = 1'b0;
        w_illegal     = 1'b0;

        case (r_state)
            S_DECODE: begin
                // Precompute the branch/jump target (old PC + imm) into ALUOut.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (bus.opcode)
                    c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
                    c_OP_RTYPE: begin
                        if (w_alu_f3_ok) w_next_state = S_EXECR;
                        else             w_illegal    = 1'b1;
                    end
                    c_OP_ITYPE: begin
                        if (w_alu_f3_ok) w_next_state = S_EXECI;
                        else             w_illegal    = 1'b1;
                    end
                    c_OP_JAL:   w_next_state = S_JAL;
                    c_OP_BRANCH: begin
                        if (w_br_f3_ok) w_next_state = S_BRANCH;
                        else            w_illegal    = 1'b1;
                    end
                    default:    w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_next_state = (bus.opcode == c_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
                w_next_state = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                // The strobe is held for the whole wait. Memory signals
                // completion through mem_ready.
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
                w_mem_write  = 1'b1;
                w_instr_done = bus.mem_ready;
                w_next_state = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b00;
                w_alu_control = w_alu_fn;
                w_next_state  = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_fn;
                w_next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = 2'b00;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut. The ALU forms old PC + 4,
                // which ALUWB then writes to rd.
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b00;
                w_pc_write   = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_BRANCH: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b00;
                w_alu_control = c_ALU_SUB;
                w_result_src  = 2'b00;
                w_pc_write    = w_br_taken;
                w_instr_done  = 1'b1;
            end
            default: begin
                // FETCH. The unreachable encodings 11-15 also land here, so a
                // corrupted state recovers by fetching again.
                w_adr_src    = 1'b0;
                w_alu_src_a  = 2'b00;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
                w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            end
        endcase
    end

    // Outputs are gated with reset. The FETCH decode is not all-zero, so
    // the state register alone cannot quiet the outputs during reset.
    assign bus.pc_write      = w_pc_write    & ~reset;
    assign bus.ir_write      = w_ir_write    & ~reset;
    assign bus.reg_write     = w_reg_write   & ~reset;
    assign bus.mem_write     = w_mem_write   & ~reset;
    assign bus.adr_src       = w_adr_src     & ~reset;
    assign bus.alu_src_a     = w_alu_src_a   & {2{~reset}};
    assign bus.alu_src_b     = w_alu_src_b   & {2{~reset}};
    assign bus.result_src    = w_result_src  & {2{~reset}};
    assign bus.alu_control   = w_alu_control & {3{~reset}};
    assign bus.instr_done    = w_instr_done  & ~reset;
    assign bus.illegal_instr = w_illegal     & ~reset;
    assign bus.state         = r_state       & {4{~reset}};

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_fsm
//  Description : Self-checking bench for control_fsm. Each instruction is
//                expanded into its list of phases by class. Stall phases
//                repeat while mem_ready is low. Every cycle's control word is
//                predicted from the phase meaning.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

    localparam logic [6:0] c_LW  = 7'b0000011;
    localparam logic [6:0] c_SW  = 7'b0100011;
    localparam logic [6:0] c_R   = 7'b0110011;
    localparam logic [6:0] c_I   = 7'b0010011;
    localparam logic [6:0] c_JAL = 7'b1101111;
    localparam logic [6:0] c_BR  = 7'b1100011;
    localparam logic [6:0] c_LUI = 7'b0110111;

    // Phase numbers equal the debug state encodings.
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3;
    localparam int P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_ALUWB = 7;
    localparam int P_EXECI = 8, P_JAL = 9, P_BRANCH = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_fsm_if bus();

    control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] obs_w;
    assign obs_w = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write,
                    bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src,
                    bus.alu_control, bus.instr_done, bus.illegal_instr};

    int n_checks = 0;
    int n_fail   = 0;
    bit mr_script[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
        bit alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
        bit br_ok  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4);
        if (op == c_LW || op == c_SW || op == c_JAL) return 1'b1;
        if (op == c_R || op == c_I) return alu_ok;
        if (op == c_BR) return br_ok;
        return 1'b0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input bit rtype, input bit f75);
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return (rtype && f75) ? 3'b001 : 3'b000;
    endfunction

    function automatic bit taken(input logic [2:0] f3, input bit z, input bit n);
        if (f3 == 3'd0) return z;
        if (f3 == 3'd1) return !z;
        if (f3 == 3'd4) return n;
        return 1'b0;
    endfunction

    function automatic logic [15:0] exp_word(input int p, input bit mr, input logic [6:0] op,
                                             input logic [2:0] f3, input bit f75,
                                             input bit z, input bit n);
        bit pcw = 0, irw = 0, rw = 0, mw = 0, adr = 0, done = 0, ill = 0;
        logic [1:0] a = 2'd0, b = 2'd0, rs = 2'd0;
        logic [2:0] alu = 3'd0;
        case (p)
            P_FETCH:    begin b = 2'd2; rs = 2'd2; pcw = mr; irw = mr; end
            P_DECODE:   begin a = 2'd1; b = 2'd1; ill = !legal(op, f3); end
            P_MEMADR:   begin a = 2'd2; b = 2'd1; end
            P_MEMREAD:  begin adr = 1; end
            P_MEMWB:    begin rs = 2'd1; rw = 1; done = 1; end
            P_MEMWRITE: begin adr = 1; mw = 1; done = mr; end
            P_EXECR:    begin a = 2'd2; alu = alu_of(f3, 1'b1, f75); end
            P_EXECI:    begin a = 2'd2; b = 2'd1; alu = alu_of(f3, 1'b0, f75); end
            P_ALUWB:    begin rw = 1; done = 1; end
            P_JAL:      begin a = 2'd1; b = 2'd2; pcw = 1; end
            P_BRANCH:   begin a = 2'd2; alu = 3'b001; done = 1; pcw = taken(f3, z, n); end
            default:    ;
        endcase
        return {pcw, irw, rw, mw, adr, a, b, rs, alu, done, ill};
    endfunction

    // Called at posedge+1 with the controller in FETCH. It returns at posedge+1
    // after the instruction's final cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit f75,
                             input bit z, input bit n, input bit all_ready);
        int ph[$];
        int k = 0, stall = 0, pcw_cnt = 0, done_cnt = 0, ill_cnt = 0, rw_cnt = 0;
        int exp_pcw;
        bit mr, ok;
        ok = legal(op, f3);
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        if (ok) begin
            if (op == c_LW) begin ph.push_back(P_MEMADR); ph.push_back(P_MEMREAD); ph.push_back(P_MEMWB); end
            else if (op == c_SW) begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWRITE); end
            else if (op == c_R) begin ph.push_back(P_EXECR); ph.push_back(P_ALUWB); end
            else if (op == c_I) begin ph.push_back(P_EXECI); ph.push_back(P_ALUWB); end
            else if (op == c_JAL) begin ph.push_back(P_JAL); ph.push_back(P_ALUWB); end
            else ph.push_back(P_BRANCH);
        end
        bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f75;
        bus.zero = z; bus.negative = n;
        while (k < ph.size()) begin
            if (mr_script.size() > 0) mr = mr_script.pop_front();
            else if (all_ready || stall >= 3) mr = 1'b1;
            else mr = ($urandom_range(0, 3) != 0);
            stall = mr ? 0 : stall + 1;
            bus.mem_ready = mr;
            #3;
            check($sformatf("state_ph%0d", ph[k]), {28'd0, bus.state}, ph[k]);
            check($sformatf("outs_st%0d_mr%0d", ph[k], mr), {16'd0, obs_w},
                  {16'd0, exp_word(ph[k], mr, op, f3, f75, z, n)});
            pcw_cnt  += int'(bus.pc_write);
            done_cnt += int'(bus.instr_done);
            ill_cnt  += int'(bus.illegal_instr);
            rw_cnt   += int'(bus.reg_write);
            if (!((ph[k] == P_FETCH || ph[k] == P_MEMREAD || ph[k] == P_MEMWRITE) && !mr)) k++;
            @(posedge clk); #1;
        end
        exp_pcw = 1 + ((op == c_JAL) ? 1 : 0) + ((ok && op == c_BR && taken(f3, z, n)) ? 1 : 0);
        check("instr_end_state", {28'd0, bus.state}, P_FETCH);
        check("pc_write_count", pcw_cnt, exp_pcw);
        check("done_count", done_cnt, ok ? 1 : 0);
        check("illegal_count", ill_cnt, ok ? 0 : 1);
        check("reg_write_count", rw_cnt, (ok && op != c_SW && op != c_BR) ? 1 : 0);
    endtask

    initial begin
        logic [6:0] op;
        reset = 1'b1;
        bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0;
        bus.zero = 1'b0; bus.negative = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        check("reset_outs", {16'd0, obs_w}, 32'd0);
        check("reset_state", {28'd0, bus.state}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // R-type sub with memory always ready.
        run_instr(c_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        // lw stalling twice in MEMREAD.
        mr_script = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run_instr(c_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        // bne not-equal (taken), then equal (not taken).
        run_instr(c_BR, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr(c_BR, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
        // lui is unsupported.
        run_instr(c_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        // FETCH waits three cycles before the ready cycle.
        mr_script = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_instr(c_I, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset taken mid-MEMWRITE while memory is stalled.
        bus.opcode = c_SW; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #1;
        check("memwrite_state", {28'd0, bus.state}, P_MEMWRITE);
        check("memwrite_strobe", {31'd0, bus.mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_reset_outs", {16'd0, obs_w}, 32'd0);
        check("mid_reset_state", {28'd0, bus.state}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("post_reset_state", {28'd0, bus.state}, 32'd0);
        check("post_reset_mem_write", {31'd0, bus.mem_write}, 32'd0);
        @(posedge clk); #1;

        // Random instruction mix with random memory stalls.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0: op = c_LW;
                1: op = c_SW;
                2: op = c_R;
                3: op = c_I;
                4: op = c_JAL;
                5: op = c_BR;
                6: op = 7'($urandom);
                default: op = c_LUI;
            endcase
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
